sprite_lbuf_writer: RTL and testbench



---
 rtl/sprite_lbuf_writer.sv | 111 +++++++++++
 tb/tb_sprite_lbuf_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_lbuf_writer.sv
// Sprite line-buffer writer: takes one 16-pixel sprite row per descriptor and
// streams its opaque pixels into the write half of a 2x512 ping-pong line
// buffer, one pixel per clock. HSTART swaps halves and aborts any row in flight.
module sprite_lbuf_writer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HSTART,
  input  logic        SVALID,
  output logic        SREADY,
  input  logic [8:0]  SX,
  input  logic        SFLIP,
  input  logic [3:0]  SPAL,
  input  logic [63:0] SPIX,
  output logic [9:0]  LB_AD,
  output logic        LB_WR,
  output logic [7:0]  LB_DI,
  output logic        WHALF,
  output logic        BUSY
);

  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [3:0]  k_reg;      // index of the next pixel to issue
  logic [8:0]  sx_reg;
  logic        flip_reg;
  logic [3:0]  pal_reg;
  logic [63:0] pix_reg;

  logic        accept;
  logic [3:0]  src;        // source pixel index after optional flip
  logic [3:0]  colour;
  logic [8:0]  x;          // wraps mod 512 by construction

  // Latched row viewed as 16 colour nibbles.
  logic [3:0]  pix_arr [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pix
      assign pix_arr[gi] = pix_reg[4*gi +: 4];
    end
  endgenerate

  // HSTART outranks a waiting descriptor so the new line starts in a clean half.
  assign SREADY = (state_reg == IDLE) & ~HSTART & ~RESET;
  assign accept = SVALID & SREADY;
  assign BUSY   = (state_reg == DRAW);

  assign src    = flip_reg ? (4'd15 - k_reg) : k_reg;
  assign colour = pix_arr[src];
  assign x      = sx_reg + {5'd0, k_reg};

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: HSTART always returns to IDLE, dropping the rest of the row.
  always_comb begin
    state_next = state_reg;
    if (HSTART) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = DRAW;
        DRAW:    if (k_reg == 4'd15) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Descriptor latch, pixel counter, half select and registered write port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      k_reg    <= 4'd0;
      sx_reg   <= 9'd0;
      flip_reg <= 1'b0;
      pal_reg  <= 4'd0;
      pix_reg  <= 64'd0;
      WHALF    <= 1'b0;
      LB_AD    <= 10'd0;
      LB_DI    <= 8'd0;
      LB_WR    <= 1'b0;
    end else begin
      LB_WR <= 1'b0;
      if (HSTART) begin
        // No write is issued on the swap edge, so nothing lands in the old half.
        WHALF <= ~WHALF;
      end else if (accept) begin
        sx_reg   <= SX;
        flip_reg <= SFLIP;
        pal_reg  <= SPAL;
        pix_reg  <= SPIX;
        k_reg    <= 4'd0;
      end else if (state_reg == DRAW) begin
        k_reg <= k_reg + 4'd1;
        // Colour 0 is transparent: the slot is used but address/data hold.
        if (colour != 4'd0) begin
          LB_WR <= 1'b1;
          LB_AD <= {WHALF, x};
          LB_DI <= {pal_reg, colour};
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_lbuf_writer.sv
// Randomised self-checking bench for sprite_lbuf_writer. Expected write
// streams are computed per row from the drawing rules (flip, transparency,
// X wrap, half select) and compared cycle by cycle.
module tb_sprite_lbuf_writer;

  logic        CLK;
  logic        RESET;
  logic        HSTART;
  logic        SVALID;
  logic        SREADY;
  logic [8:0]  SX;
  logic        SFLIP;
  logic [3:0]  SPAL;
  logic [63:0] SPIX;
  logic [9:0]  LB_AD;
  logic        LB_WR;
  logic [7:0]  LB_DI;
  logic        WHALF;
  logic        BUSY;

  sprite_lbuf_writer dut (
    .CLK(CLK), .RESET(RESET), .HSTART(HSTART), .SVALID(SVALID), .SREADY(SREADY),
    .SX(SX), .SFLIP(SFLIP), .SPAL(SPAL), .SPIX(SPIX),
    .LB_AD(LB_AD), .LB_WR(LB_WR), .LB_DI(LB_DI), .WHALF(WHALF), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference state.
  bit          m_whalf   = 1'b0;
  logic [9:0]  m_ad_hold = 10'd0;
  logic [7:0]  m_di_hold = 8'd0;
  int unsigned last_acc  = 0;
  int          last_writes;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one descriptor starting at a negedge and follow it through.
  // abort_k < 16 pulses HSTART in the cycle where pixel abort_k is pending.
  task automatic run_row(input logic [8:0] sx, input bit flip, input logic [3:0] pal,
                         input logic [63:0] pix, input int abort_k, input bit collide,
                         input bit chk_spacing);
    int       nwr;
    int       s;
    logic [3:0] c;
    logic [8:0] xx;
    nwr = 0;
    SX = sx; SFLIP = flip; SPAL = pal; SPIX = pix; SVALID = 1'b1;
    if (collide) HSTART = 1'b1;
    #1;
    check("sready_offer", SREADY, !collide);
    if (collide) begin
      @(negedge CLK);
      HSTART = 1'b0;
      m_whalf = ~m_whalf;
      check("collide_whalf", WHALF, m_whalf);
      check("collide_busy", BUSY, 0);
      check("collide_wr", LB_WR, 0);
      #1;
      check("collide_sready", SREADY, 1);
    end
    @(negedge CLK);
    // Accepted at the edge just passed; scramble inputs to prove they are latched.
    SVALID = 1'b0;
    SX = 9'($urandom); SFLIP = 1'($urandom); SPAL = 4'($urandom); SPIX = {$urandom, $urandom};
    if (chk_spacing) check("accept_spacing", cyc - last_acc, 17);
    last_acc = cyc;
    check("busy_start", BUSY, 1);
    check("sready_busy", SREADY, 0);
    check("wr_first", LB_WR, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == abort_k) HSTART = 1'b1;
      @(negedge CLK);
      if (k == abort_k) begin
        HSTART = 1'b0;
        m_whalf = ~m_whalf;
        check("abort_wr", LB_WR, 0);
        check("abort_busy", BUSY, 0);
        check("abort_whalf", WHALF, m_whalf);
        #1;
        check("abort_sready", SREADY, 1);
        last_writes = nwr;
        return;
      end
      s  = flip ? 15 - k : k;
      c  = pix[4*s +: 4];
      xx = sx + 9'(k);
      check("busy_draw", BUSY, k != 15);
      check("wr", LB_WR, c != 4'd0);
      if (c != 4'd0) begin
        m_ad_hold = {m_whalf, xx};
        m_di_hold = {pal, c};
        nwr++;
      end
      check("ad", LB_AD, m_ad_hold);
      check("di", LB_DI, m_di_hold);
    end
    check("sready_end", SREADY, 1);
    last_writes = nwr;
  endtask

  initial begin
    logic [63:0] pix;
    int          ak;
    bit          col;
    bit          prev_full;

    RESET = 1'b1; HSTART = 1'b0; SVALID = 1'b0;
    SX = '0; SFLIP = 1'b0; SPAL = '0; SPIX = '0;
    repeat (2) @(negedge CLK);
    check("rst_wr", LB_WR, 0);
    check("rst_ad", LB_AD, 0);
    check("rst_di", LB_DI, 0);
    check("rst_whalf", WHALF, 0);
    check("rst_busy", BUSY, 0);
    check("rst_sready", SREADY, 0);
    RESET = 1'b0;
    #1;
    check("rel_sready", SREADY, 1);
    @(negedge CLK);

    // Basic row: 15 opaque pixels, last one transparent.
    run_row(9'h010, 1'b0, 4'h5, 64'h0123456789ABCDEF, 99, 1'b0, 1'b0);
    check("basic_nwr", last_writes, 15);
    // Flipped: first slot transparent.
    run_row(9'h100, 1'b1, 4'h5, 64'h0123456789ABCDEF, 99, 1'b0, 1'b1);
    // Wrap across x = 511 -> 0.
    run_row(9'h1FE, 1'b0, 4'h0, 64'h3333333333333333, 99, 1'b0, 1'b1);
    check("wrap_nwr", last_writes, 16);
    // HSTART while pixel 5 pending: five writes, then the next row in half 1.
    run_row(9'h040, 1'b0, 4'hA, 64'h1111111111111111, 5, 1'b0, 1'b1);
    check("abort_nwr", last_writes, 5);
    run_row(9'h020, 1'b0, 4'h2, 64'h2222222222222222, 99, 1'b0, 1'b0);
    check("after_abort_half", LB_AD[9], 1);
    // Collision with HSTART, then back-to-back.
    run_row(9'h080, 1'b0, 4'h7, 64'h7654321076543210, 99, 1'b1, 1'b0);
    run_row(9'h090, 1'b1, 4'h8, 64'hFEDCBA98FEDCBA98, 99, 1'b0, 1'b1);

    // Random rows with occasional aborts and collisions.
    prev_full = 1'b1;
    for (int r = 0; r < 30; r++) begin
      pix = {$urandom, $urandom};
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 3) == 0) pix[4*i +: 4] = 4'd0;
      ak  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 99;
      col = ($urandom_range(0, 5) == 0);
      run_row(9'($urandom), 1'($urandom), 4'($urandom), pix, ak, col, prev_full && !col);
      prev_full = (ak == 99);
    end

    // Asynchronous reset in the middle of a row, with WHALF forced to 1 first.
    if (!m_whalf) begin
      HSTART = 1'b1;
      @(negedge CLK);
      HSTART = 1'b0;
      m_whalf = 1'b1;
    end
    SX = 9'h0; SFLIP = 1'b0; SPAL = 4'hC; SPIX = 64'hFFFFFFFFFFFFFFFF; SVALID = 1'b1;
    @(negedge CLK);
    SVALID = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_rst_wr", LB_WR, 1);
    check("pre_rst_whalf", WHALF, 1);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_wr", LB_WR, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_whalf", WHALF, 0);
    check("mid_rst_sready", SREADY, 0);
    @(negedge CLK);
    RESET = 1'b0;
    m_whalf = 1'b0; m_ad_hold = 10'd0; m_di_hold = 8'd0;
    #1;
    check("post_rst_sready", SREADY, 1);
    @(negedge CLK);
    check("post_rst_wr", LB_WR, 0);
    check("post_rst_busy", BUSY, 0);
    run_row(9'h1F0, 1'b0, 4'h9, 64'h0F0F0F0F0F0F0F0F, 99, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
